vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator. Produces hsync, vsync, display-enable,
//  pixel coordinates, line/frame strobes and a frame counter from a single pixel clock.
//  Replaces the separate fixed 1024x768 line/frame sync blocks: one counter pair, runtime
//  pixel-clock enable, selectable sync polarity. Feeds the waveform renderer and VGA pins.
// PARAMETERS
//  H_VIS    1024  visible pixels per line
//  H_FP     24    horizontal front porch, pixels
//  H_SYNC   136   horizontal sync width, pixels (>=1)
//  H_BP     160   horizontal back porch, pixels
//  V_VIS    768   visible lines per frame
//  V_FP     3     vertical front porch, lines
//  V_SYNC   6     vertical sync width, lines (>=1)
//  V_BP     29    vertical back porch, lines
//  H_POL    0     hsync active level (0 = active-low)
//  V_POL    0     vsync active level (0 = active-low)
//  CNT_W    11    counter/coordinate width; H_TOTAL, V_TOTAL <= 2**CNT_W (elaboration error otherwise)
//  FCNT_W   8     frame counter width
// PORTS
//  clk          in   1        pixel clock
//  rst_n        in   1        asynchronous reset, active-low
//  ce           in   1        pixel clock enable; counters/outputs advance only when 1
//  hsync        out  1        horizontal sync, level per H_POL
//  vsync        out  1        vertical sync, level per V_POL
//  de           out  1        display enable: 1 inside visible area
//  x            out  CNT_W    horizontal position of presented pixel (0..H_TOTAL-1)
//  y            out  CNT_W    vertical position of presented pixel (0..V_TOTAL-1)
//  line_start   out  1        one-clk strobe: presented x==0
//  frame_start  out  1        one-clk strobe: presented x==0 && y==0
//  vblank       out  1        1 while presented y >= V_VIS
//  frame_cnt    out  FCNT_W   frames started since reset, wraps to 0
// BEHAVIOUR
//  - H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults: 1344 x 806.
//  - Internal counters h,v reset to 0. On each clk edge with ce=1: all outputs are registered
//    from decode of current (h,v), then h<=h+1; at h==H_TOTAL-1: h<=0 and v advances;
//    at v==V_TOTAL-1 with h wrap: v<=0. Outputs lag counters by exactly one ce cycle.
//  - ce=0: counters and x,y,hsync,vsync,de,vblank,frame_cnt hold.
//  - Decode (inclusive ranges): de = h<H_VIS && v<V_VIS;
//    hsync active for h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1];
//    vsync active for v in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], whole lines, changes at h wrap.
//  - line_start/frame_start set in a ce cycle presenting the qualifying position; cleared
//    on the next clk edge regardless of ce (exactly one clk wide).
//  - frame_cnt increments in the same ce cycle frame_start is set; FCNT_W wrap-around, no flag.
//    The first frame after reset presents frame_cnt=1.
//  - Reset (async assert, sync release on clk): h=v=0, x=y=0, de=0, vblank=0,
//    hsync=~H_POL, vsync=~V_POL, strobes=0, frame_cnt=0. First ce cycle after release
//    presents (0,0) with de=1, line_start=frame_start=1.
//  - Reset asserted mid-frame: outputs go to reset values immediately (no clk needed);
//    raster restarts at (0,0), no partial-line completion.
//  - No other states; counters never exceed TOTAL-1 (wrap compare is ==, not <).
// TESTING
//  T1 default params, ce=1, run 2 frames: hsync low exactly 136 clks/line starting x=1048,
//     vsync low exactly 6 lines starting y=771, de high 1024x768 per frame, period 1083264 clks.
//  T2 small params H 8/2/2/2, V 4/1/1/1 (14x7): x wraps 13->0, y wraps 6->0, frame_start every
//     98 clks, line_start every 14 clks, each exactly 1 clk wide.
//  T3 ce toggling 1,0,0,1 pattern: x/y advance once per ce=1, outputs hold during ce=0,
//     strobes still 1 clk wide; 14x7 frame takes 98 ce pulses.
//  T4 H_POL=1,V_POL=1: sync levels inverted; idle level after reset is 0.
//  T5 FCNT_W=2, run 5 frames: frame_cnt sequence 1,2,3,0,1.
//  T6 assert rst_n at x=5,y=3 between clk edges: all outputs reset asynchronously; after
//     release first ce presents x=0,y=0,de=1,frame_start=1,frame_cnt=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: one h/v counter pair with a runtime pixel
// clock enable. All outputs are registered and lag the counters by one enabled cycle.
module vga_timing_gen #(
  parameter int H_VIS  = 1024,
  parameter int H_FP   = 24,
  parameter int H_SYNC = 136,
  parameter int H_BP   = 160,
  parameter int V_VIS  = 768,
  parameter int V_FP   = 3,
  parameter int V_SYNC = 6,
  parameter int V_BP   = 29,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0,
  parameter int CNT_W  = 11,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [CNT_W-1:0]  x,
  output logic [CNT_W-1:0]  y,
  output logic              line_start,
  output logic              frame_start,
  output logic              vblank,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_width_check
    $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end
  if (H_SYNC < 1 || V_SYNC < 1) begin : g_sync_check
    $error("vga_timing_gen: sync widths must be at least 1");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             h_wrap;
  logic             v_wrap;
  logic             de_dec;
  logic             hs_act;
  logic             vs_act;
  logic             origin;

  always_comb begin
    h_wrap = (h == H_LAST);
    v_wrap = (v == V_LAST);
    de_dec = (h < H_VIS_C) && (v < V_VIS_C);
    hs_act = (h >= HS_FIRST) && (h <= HS_LAST);
    vs_act = (v >= VS_FIRST) && (v <= VS_LAST);
    origin = (h == '0) && (v == '0);
  end

  // Wrap compares use equality so the counters can never run past TOTAL-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (ce) begin
      if (h_wrap) begin
        h <= '0;
        v <= v_wrap ? '0 : v + CNT_W'(1);
      end else begin
        h <= h + CNT_W'(1);
      end
    end
  end

  // Strobes drop on every clk edge so they stay one clk wide even when ce is sparse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      vblank      <= 1'b0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        x           <= h;
        y           <= v;
        de          <= de_dec;
        vblank      <= (v >= V_VIS_C);
        hsync       <= hs_act ? H_POL : ~H_POL;
        vsync       <= vs_act ? V_POL : ~V_POL;
        line_start  <= (h == '0);
        frame_start <= origin;
        if (origin) begin
          frame_cnt <= frame_cnt + FCNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three instances (default 1344x806, 14x7 active-low,
// 14x7 active-high with 2-bit frame counter) driven by random ce against an arithmetic model.
module tb_vga_timing_gen;

  localparam int HV[3]  = '{1024, 8, 8};
  localparam int HFP[3] = '{24, 2, 2};
  localparam int HSW[3] = '{136, 2, 2};
  localparam int HBP[3] = '{160, 2, 2};
  localparam int VV[3]  = '{768, 4, 4};
  localparam int VFP[3] = '{3, 1, 1};
  localparam int VSW[3] = '{6, 1, 1};
  localparam int VBP[3] = '{29, 1, 1};
  localparam bit HP[3]  = '{1'b0, 1'b0, 1'b1};
  localparam bit VP[3]  = '{1'b0, 1'b0, 1'b1};
  localparam int FW[3]  = '{8, 8, 2};

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        vb;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } obs_t;

  typedef struct packed {
    logic [1:0] inst;
    obs_t       o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ce_v [3];

  logic        hs_d, vs_d, de_d, ls_d, fs_d, vb_d;
  logic [10:0] x_d, y_d;
  logic [7:0]  fc_d;
  logic        hs_a, vs_a, de_a, ls_a, fs_a, vb_a;
  logic [3:0]  x_a, y_a;
  logic [7:0]  fc_a;
  logic        hs_b, vs_b, de_b, ls_b, fs_b, vb_b;
  logic [3:0]  x_b, y_b;
  logic [1:0]  fc_b;

  obs_t obs_d, obs_a, obs_b;
  exp_t sb[$];
  obs_t last_exp [3];
  int   n [3];
  int   errors = 0;
  int   checks = 0;
  bit   monitor_on = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VIS(HV[0]), .H_FP(HFP[0]), .H_SYNC(HSW[0]), .H_BP(HBP[0]),
    .V_VIS(VV[0]), .V_FP(VFP[0]), .V_SYNC(VSW[0]), .V_BP(VBP[0]),
    .H_POL(HP[0]), .V_POL(VP[0]), .CNT_W(11), .FCNT_W(FW[0])
  ) dut_d (
    .clk(clk), .rst_n(rst_n), .ce(ce_v[0]), .hsync(hs_d), .vsync(vs_d), .de(de_d),
    .x(x_d), .y(y_d), .line_start(ls_d), .frame_start(fs_d), .vblank(vb_d), .frame_cnt(fc_d)
  );

  vga_timing_gen #(
    .H_VIS(HV[1]), .H_FP(HFP[1]), .H_SYNC(HSW[1]), .H_BP(HBP[1]),
    .V_VIS(VV[1]), .V_FP(VFP[1]), .V_SYNC(VSW[1]), .V_BP(VBP[1]),
    .H_POL(HP[1]), .V_POL(VP[1]), .CNT_W(4), .FCNT_W(FW[1])
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ce(ce_v[1]), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a), .vblank(vb_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_VIS(HV[2]), .H_FP(HFP[2]), .H_SYNC(HSW[2]), .H_BP(HBP[2]),
    .V_VIS(VV[2]), .V_FP(VFP[2]), .V_SYNC(VSW[2]), .V_BP(VBP[2]),
    .H_POL(HP[2]), .V_POL(VP[2]), .CNT_W(4), .FCNT_W(FW[2])
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ce(ce_v[2]), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b), .vblank(vb_b), .frame_cnt(fc_b)
  );

  assign obs_d = {5'd0, x_d, 5'd0, y_d, de_d, hs_d, vs_d, vb_d, ls_d, fs_d, fc_d};
  assign obs_a = {12'd0, x_a, 12'd0, y_a, de_a, hs_a, vs_a, vb_a, ls_a, fs_a, fc_a};
  assign obs_b = {12'd0, x_b, 12'd0, y_b, de_b, hs_b, vs_b, vb_b, ls_b, fs_b, 6'd0, fc_b};

  function automatic obs_t get_obs(int i);
    case (i)
      0:       return obs_d;
      1:       return obs_a;
      default: return obs_b;
    endcase
  endfunction

  // Expected presentation for the k-th enabled cycle since reset, from raster arithmetic.
  function automatic obs_t model(int i, int k);
    obs_t e;
    int ht, vt, p, h, v, hs0, vs0;
    ht  = HV[i] + HFP[i] + HSW[i] + HBP[i];
    vt  = VV[i] + VFP[i] + VSW[i] + VBP[i];
    p   = k % (ht * vt);
    h   = p % ht;
    v   = p / ht;
    hs0 = HV[i] + HFP[i];
    vs0 = VV[i] + VFP[i];
    e.x  = 16'(h);
    e.y  = 16'(v);
    e.de = (h < HV[i]) && (v < VV[i]);
    e.hs = (h >= hs0 && h < hs0 + HSW[i]) ? HP[i] : !HP[i];
    e.vs = (v >= vs0 && v < vs0 + VSW[i]) ? VP[i] : !VP[i];
    e.vb = (v >= VV[i]);
    e.ls = (h == 0);
    e.fs = (p == 0);
    e.fc = 8'((k / (ht * vt) + 1) % (1 << FW[i]));
    return e;
  endfunction

  function automatic obs_t reset_obs(int i);
    obs_t e;
    e    = '0;
    e.hs = !HP[i];
    e.vs = !VP[i];
    return e;
  endfunction

  task automatic check_output(string name, int i, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst=%0d got x=%0d y=%0d de=%b hs=%b vs=%b vb=%b ls=%b fs=%b fc=%0d expected x=%0d y=%0d de=%b hs=%b vs=%b vb=%b ls=%b fs=%b fc=%0d",
               name, i, got.x, got.y, got.de, got.hs, got.vs, got.vb, got.ls, got.fs, got.fc,
               exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.vb, exp.ls, exp.fs, exp.fc);
    end
  endtask

  // mode 0: random ce, mode 1: repeating 1,0,0,1 pattern, mode 2: ce held high.
  task automatic apply_stimulus(int cycles, int mode);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        case (mode)
          0:       ce_v[i] = (i == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
          1:       ce_v[i] = (c % 4 == 0) || (c % 4 == 3);
          default: ce_v[i] = 1'b1;
        endcase
        if (ce_v[i]) begin
          sb.push_back({2'(i), model(i, n[i])});
          n[i]++;
        end
      end
    end
  endtask

  task automatic restart_tracking();
    for (int i = 0; i < 3; i++) begin
      n[i]        = 0;
      last_exp[i] = reset_obs(i);
    end
  endtask

  // Monitor: an enabled edge consumes a scoreboard entry; otherwise outputs must hold
  // with both strobes already back to 0.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (monitor_on) begin
        for (int i = 0; i < 3; i++) begin
          if (ce_v[i]) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL sb_underflow inst=%0d got empty queue expected an entry", i);
            end else begin
              e = sb.pop_front();
              if (int'(e.inst) != i) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_order got inst=%0d expected inst=%0d", e.inst, i);
              end
              check_output("ce_cycle", i, get_obs(i), e.o);
              last_exp[i]    = e.o;
              last_exp[i].ls = 1'b0;
              last_exp[i].fs = 1'b0;
            end
          end else begin
            check_output("hold", i, get_obs(i), last_exp[i]);
          end
        end
      end
    end
  end

  initial begin
    bit   found;
    obs_t p;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) ce_v[i] = 1'b0;
    restart_tracking();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check_output("reset_state", i, get_obs(i), reset_obs(i));
    rst_n      = 1'b1;
    monitor_on = 1'b1;

    apply_stimulus(3000, 0);
    apply_stimulus(600, 1);

    found = 1'b0;
    for (int g = 0; g < 2000 && !found; g++) begin
      apply_stimulus(1, 0);
      if (n[1] > 0) begin
        p = model(1, n[1] - 1);
        found = (p.x == 16'd5) && (p.y == 16'd3);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL find_pos got no x=5 y=3 within bound expected position reached");
    end

    // Assert reset between edges and look before any further clock edge.
    @(posedge clk);
    #2;
    monitor_on = 1'b0;
    for (int i = 0; i < 3; i++) ce_v[i] = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check_output("async_reset", i, get_obs(i), reset_obs(i));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    restart_tracking();
    monitor_on = 1'b1;

    apply_stimulus(3000, 2);
    apply_stimulus(1500, 0);
    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
